// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Definitions shared by the fetch and decode stages of the 5-stage core:
// data-path width, the canonical NOP encoding, base opcode constants, the
// packed fetch-FIFO entry layout and a word-alignment helper.
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Base opcodes (instr[6:0]) shared with decode
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;

   // One instruction-FIFO entry: the PC travels with its instruction word
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Force an address onto a 32-bit word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage : core_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used by the fetch stage, both as the PC-tag queue and
// as the instruction buffer. The head entry is read combinationally from
// storage. flush_i empties the FIFO and wins over a push/pop in the same cycle.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop happens in the same cycle (count unchanged).
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         discard all entries
//   push_i/wdata_i  write one entry
//   pop_i           remove the head entry
//   rdata_o         head entry (valid when !empty_o)
//   count_o         number of stored entries (0..DEPTH)
//   full_o/empty_o  status flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic do_push_s;
   logic do_pop_s;

   assign empty_o = (count_q == {CNT_W{1'b0}});
   assign full_o  = (count_q == DEPTH_C);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata_i;
            // DEPTH is a power of two, so the pointer wraps naturally
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + {{(CNT_W-1){1'b0}}, do_push_s}
                           - {{(CNT_W-1){1'b0}}, do_pop_s};
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the PC, issues word requests to instruction
// memory (req/gnt/rvalid, in-order responses), buffers returned words with
// their PCs and presents one instruction per cycle to decode. A redirect from
// EX flushes buffered work and discards responses still in flight.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   DEPTH      instruction FIFO entries = maximum outstanding requests
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o        request valid / word-aligned address
//   imem_gnt_i                     request accepted this cycle
//   imem_rvalid_i, imem_rdata_i    response valid / instruction word
//   redirect_i, redirect_pc_i      taken branch/jump and its target
//   id_ready_i                     decode accepts the head instruction
//   instr_vld_o, instr_o, pc_o     head instruction (NOP when invalid) and PC
// -----------------------------------------------------------------------------
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        instr_vld_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam int               CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];
   localparam logic [CNT_W:0]   DEPTH_X = DEPTH[CNT_W:0];

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             gnt_hs_s;
   logic             dropping_s;
   logic             keep_rsp_s;
   logic [CNT_W:0]   credit_use_s;

   logic             tag_push_s, tag_pop_s;
   logic [31:0]      tag_rdata_s;
   logic [CNT_W-1:0] tag_count_s;
   logic             tag_full_s, tag_empty_s;

   logic             fifo_push_s, fifo_pop_s;
   fetch_entry_t     fifo_wdata_s, fifo_head_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             fifo_full_s, fifo_empty_s;

   // Credits in use: in-flight requests plus buffered words, minus the entry
   // decode removes this cycle. Counting the pop keeps the stage at one
   // instruction per cycle with DEPTH=2 and 1-cycle memory, while the sum
   // still never exceeds DEPTH, so the instruction FIFO cannot overflow.
   assign credit_use_s = {1'b0, outstanding_q} + {1'b0, fifo_count_s}
                       - {{CNT_W{1'b0}}, fifo_pop_s};

   // Held low in reset and on a redirect cycle. The tag-queue and FIFO-full
   // terms are defensive; the credit check already implies them.
   assign imem_req_o  = rst_ni & ~redirect_i & (credit_use_s < DEPTH_X)
                      & (tag_count_s < DEPTH_C)
                      & (~fifo_full_s | fifo_pop_s);
   assign imem_addr_o = word_align(pc_q);
   assign gnt_hs_s    = imem_req_o & imem_gnt_i;

   // Responses are in order, so while drop_cnt is non-zero the arriving word
   // belongs to a request issued before the last redirect.
   assign dropping_s = imem_rvalid_i & (drop_cnt_q != {CNT_W{1'b0}});
   assign keep_rsp_s = imem_rvalid_i & (drop_cnt_q == {CNT_W{1'b0}}) & ~redirect_i;

   // The tag queue only holds tags of right-path requests (it is cleared on a
   // redirect), so dropped responses must not pop it.
   assign tag_push_s  = gnt_hs_s & ~tag_full_s;
   assign tag_pop_s   = keep_rsp_s & ~tag_empty_s;
   assign fifo_push_s = keep_rsp_s;
   assign fifo_wdata_s.pc    = tag_rdata_s;
   assign fifo_wdata_s.instr = imem_rdata_i;
   assign fifo_pop_s  = ~fifo_empty_s & id_ready_i & ~redirect_i;

   assign instr_vld_o = ~fifo_empty_s;
   assign instr_o     = fifo_empty_s ? NOP_INSTR : fifo_head_s.instr;
   assign pc_o        = fifo_empty_s ? 32'h0000_0000 : fifo_head_s.pc;

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (tag_push_s),
      .wdata_i (imem_addr_o),
      .pop_i   (tag_pop_s),
      .rdata_o (tag_rdata_s),
      .count_o (tag_count_s),
      .full_o  (tag_full_s),
      .empty_o (tag_empty_s)
   );

   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_instr_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (fifo_push_s),
      .wdata_i (fifo_wdata_s),
      .pop_i   (fifo_pop_s),
      .rdata_o (fifo_head_s),
      .count_o (fifo_count_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Next PC, in-flight request count and pending-discard count
   always_comb begin
      pc_d          = pc_q;
      drop_cnt_d    = drop_cnt_q;
      // Old requests stay in flight across a redirect, so this is unaffected
      outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, gnt_hs_s}
                                    - {{(CNT_W-1){1'b0}}, imem_rvalid_i};
      if (redirect_i) begin
         pc_d       = word_align(redirect_pc_i);
         // Everything still in flight after this cycle is wrong-path
         drop_cnt_d = outstanding_q - {{(CNT_W-1){1'b0}}, imem_rvalid_i};
      end else begin
         if (gnt_hs_s) begin
            pc_d = pc_q + 32'd4;
         end else begin
            pc_d = pc_q;
         end
         if (dropping_s) begin
            drop_cnt_d = drop_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end
   end

   // Fetch control registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q          <= word_align(RESET_PC);
         outstanding_q <= {CNT_W{1'b0}};
         drop_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed and randomized stimulus for fetch_unit. A behavioural memory
// (queue of pending responses with per-request latency) answers requests, and
// a reference model tracks the next expected request address and the next
// expected instruction PC purely from the architectural rules: sequential +4,
// restart at the aligned target on a redirect, restart at RESET_PC on reset.
// Instruction words are a fixed hash of their address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import core_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_ready_i;
   logic        instr_vld_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;

   always #5 clk_i = ~clk_i;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_ready_i    (id_ready_i),
      .instr_vld_o   (instr_vld_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc;
   int          last_due;
   int          lat_min;
   int          lat_max;
   int          gnt_pct;
   logic [31:0] exp_pc;
   logic [31:0] exp_req_pc;
   int          n_checks;
   int          n_fail;
   int          n_cons;
   bit          cons_flag;
   logic [31:0] cons_pc;
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_vld;
   logic [31:0] s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory drives grant and the oldest due response; called just after posedge
   task automatic drive_mem();
      imem_gnt_i = (int'($urandom_range(99, 0)) < gnt_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(mq[0].addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'h0000_0000;
      end
   endtask

   // One clock cycle: drive memory, sample and check at negedge, update models
   task automatic cycle();
      int due;
      drive_mem();
      @(negedge clk_i);
      s_req     = imem_req_o;
      s_addr    = imem_addr_o;
      s_vld     = instr_vld_o;
      s_pc      = pc_o;
      cons_flag = 1'b0;
      if (redirect_i) chk("req_low_on_redirect", 32'(imem_req_o), 32'd0);
      if (imem_req_o) chk("req_addr", imem_addr_o, exp_req_pc);
      if (!instr_vld_o) chk("nop_when_invalid", instr_o, NOP_INSTR);
      if (instr_vld_o && id_ready_i && !redirect_i) begin
         chk("pc_stream", pc_o, exp_pc);
         chk("instr_stream", instr_o, mem_word(exp_pc));
         cons_flag = 1'b1;
         cons_pc   = pc_o;
         exp_pc    = exp_pc + 32'd4;
         n_cons++;
      end
      if (imem_req_o && imem_gnt_i) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         mq.push_back('{imem_addr_o, due});
         last_due   = due;
         exp_req_pc = exp_req_pc + 32'd4;
      end
      if (imem_rvalid_i) mq.delete(0);
      if (redirect_i) begin
         exp_pc     = {redirect_pc_i[31:2], 2'b00};
         exp_req_pc = {redirect_pc_i[31:2], 2'b00};
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_ni        = 1'b0;
      redirect_i    = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0000_0000;
      mq.delete();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni     = 1'b1;
      cyc        = 0;
      last_due   = 0;
      exp_pc     = 32'h0000_0000;
      exp_req_pc = 32'h0000_0000;
   endtask

   // Run until decode consumes an instruction (bounded)
   task automatic wait_cons(input string tag, output logic [31:0] pc);
      bit found;
      found = 1'b0;
      pc    = 32'hFFFF_FFFF;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle();
         if (cons_flag) begin
            found = 1'b1;
            pc    = cons_pc;
         end
      end
      if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pcv;
      int          base;
      bit          hit;
      n_checks      = 0;
      n_fail        = 0;
      n_cons        = 0;
      rst_ni        = 1'b0;
      id_ready_i    = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0000_0000;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0000_0000;
      gnt_pct       = 100;
      lat_min       = 1;
      lat_max       = 1;
      cyc           = 0;
      last_due      = 0;
      exp_pc        = 32'h0000_0000;
      exp_req_pc    = 32'h0000_0000;

      // Values while reset is held
      #12;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_vld", 32'(instr_vld_o), 32'd0);
      chk("rst_instr", instr_o, NOP_INSTR);
      chk("rst_pc", pc_o, 32'h0000_0000);

      // Streaming: always grant, 1-cycle latency, decode always ready
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("stream_req", 32'(s_req), 32'd1);
         chk("stream_vld", 32'(s_vld), 32'(i >= 2));
         if (i >= 2) chk("stream_consume", 32'(cons_flag), 32'd1);
      end

      // Decode stalled for 5 cycles from reset
      do_reset();
      id_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_req", 32'(s_req), 32'(i < 2));
         if (i >= 2) begin
            chk("stall_vld", 32'(s_vld), 32'd1);
            chk("stall_head_pc", s_pc, 32'h0000_0000);
         end
      end
      id_ready_i = 1'b1;
      wait_cons("resume0", pcv);
      chk("resume0_pc", pcv, 32'h0000_0000);
      wait_cons("resume1", pcv);
      chk("resume1_pc", pcv, 32'h0000_0004);
      wait_cons("resume2", pcv);
      chk("resume2_pc", pcv, 32'h0000_0008);

      // Redirect with two requests in flight (3-cycle latency)
      do_reset();
      lat_min = 3;
      lat_max = 3;
      cycle();
      cycle();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0100;
      cycle();
      redirect_i = 1'b0;
      wait_cons("redir_first", pcv);
      chk("redir_first_pc", pcv, 32'h0000_0100);
      wait_cons("redir_second", pcv);
      chk("redir_second_pc", pcv, 32'h0000_0104);

      // Misaligned redirect target, 1-cycle latency
      lat_min = 1;
      lat_max = 1;
      repeat (8) cycle();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0203;
      cycle();
      redirect_i = 1'b0;
      cycle();
      chk("misalign_req_next", 32'(s_req), 32'd1);
      chk("misalign_addr", s_addr, 32'h0000_0200);
      wait_cons("misalign", pcv);
      chk("misalign_pc", pcv, 32'h0000_0200);

      // PC wrap at the top of the address space
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      cycle();
      redirect_i = 1'b0;
      wait_cons("wrap_top", pcv);
      chk("wrap_top_pc", pcv, 32'hFFFF_FFFC);
      wait_cons("wrap_zero", pcv);
      chk("wrap_zero_pc", pcv, 32'h0000_0000);

      // Randomized grant, latency, decode readiness and redirects
      do_reset();
      gnt_pct = 50;
      lat_min = 1;
      lat_max = 3;
      base    = n_cons;
      for (int i = 0; i < 2500; i++) begin
         id_ready_i    = (int'($urandom_range(99, 0)) < 70);
         redirect_i    = (int'($urandom_range(99, 0)) < 3);
         redirect_pc_i = $urandom;
         cycle();
      end
      redirect_i = 1'b0;
      id_ready_i = 1'b1;
      chk("random_progress", 32'((n_cons - base) > 100), 32'd1);

      // Reset asserted mid-stream once PC 0x40 has been consumed
      do_reset();
      gnt_pct = 100;
      lat_min = 1;
      lat_max = 1;
      hit     = 1'b0;
      for (int k = 0; k < 60 && !hit; k++) begin
         cycle();
         if (cons_flag && cons_pc == 32'h0000_0040) hit = 1'b1;
      end
      chk("midrst_reached_0x40", 32'(hit), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_vld", 32'(instr_vld_o), 32'd0);
      chk("midrst_instr", instr_o, NOP_INSTR);
      chk("midrst_pc", pc_o, 32'h0000_0000);
      chk("midrst_req", 32'(imem_req_o), 32'd0);
      do_reset();
      cycle();
      chk("midrst_restart_req", 32'(s_req), 32'd1);
      chk("midrst_restart_addr", s_addr, 32'h0000_0000);
      wait_cons("midrst_first", pcv);
      chk("midrst_first_pc", pcv, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit
